btn_events: RTL and testbench

Button gesture decoder on the consuming side of the debounced button line. Takes the clean, active-low level from the debouncer and turns it into single-cycle event pulses: press, short click, long press, and auto-repeat while held. Sits between the debouncer and the timer set/start logic, so that logic never handles raw levels or hold timing.

---
 rtl/btn_events.sv | 119 +++++++++++
 tb/tb_btn_events.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/btn_events.sv
// Button gesture decoder: turns the debounced active-low button level into
// single-cycle press / click / long / repeat / release pulses plus a held level.
module btn_events #(
    parameter int CNT_W    = 25,
    parameter int LONG_T   = 25175000,
    parameter int REPEAT_T = 5035000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_p,
    output logic click_p,
    output logic long_p,
    output logic rep_p,
    output logic rel_p,
    output logic held
);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REPEAT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_T - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             rel_q, rel_d;
    logic             held_q, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            press_q <= 1'b0;
            click_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            click_q <= click_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    // The state itself remembers the previous button level, so no separate
    // edge detector is needed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        click_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                if (btn_n) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!btn_n) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (btn_n) begin
                    click_d = 1'b1;
                    rel_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (btn_n) begin
                    rel_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_REPEAT);
    end

    assign press_p = press_q;
    assign click_p = click_q;
    assign long_p  = long_q;
    assign rep_p   = rep_q;
    assign rel_p   = rel_q;
    assign held    = held_q;

endmodule

// File: tb/tb_btn_events.sv
// Directed bench for btn_events with LONG_T=8, REPEAT_T=3, CNT_W=4.
// Output vector order: {press_p, click_p, long_p, rep_p, rel_p, held}.
module tb_btn_events;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic press_p, click_p, long_p, rep_p, rel_p, held;

    int n_cmp = 0;
    int n_bad = 0;

    btn_events #(
        .CNT_W   (4),
        .LONG_T  (8),
        .REPEAT_T(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
        .press_p(press_p),
        .click_p(click_p),
        .long_p (long_p),
        .rep_p  (rep_p),
        .rel_p  (rel_p),
        .held   (held)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {press_p, click_p, long_p, rep_p, rel_p, held};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = outs();
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("%s: btn_n=%b outs=%b expected=%b", tag, btn_n, obs, exp);
    endtask

    // Drive btn_n away from the edge, let one rising edge sample it, then check.
    task automatic step(input string tag, input logic b, input logic [5:0] exp);
        btn_n = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        // Reset with button released
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 6'b000000);
        rst_n = 1'b1;
        step("wait_to_idle", 1'b1, 6'b000000);

        // 1: low E0..E4, high at E5
        step("t1_E0_press", 1'b0, 6'b100001);
        for (int i = 1; i <= 4; i++) step("t1_hold", 1'b0, 6'b000001);
        step("t1_E5_click", 1'b1, 6'b010010);
        step("t1_idle", 1'b1, 6'b000000);

        // 2a: low E0..E7, high at E8 -> click, no long
        step("t2a_E0_press", 1'b0, 6'b100001);
        for (int i = 1; i <= 7; i++) step("t2a_hold", 1'b0, 6'b000001);
        step("t2a_E8_click", 1'b1, 6'b010010);
        step("t2a_idle", 1'b1, 6'b000000);

        // 2b: low through E8 -> long, release gives rel only
        step("t2b_E0_press", 1'b0, 6'b100001);
        for (int i = 1; i <= 7; i++) step("t2b_hold", 1'b0, 6'b000001);
        step("t2b_E8_long", 1'b0, 6'b001001);
        step("t2b_E9_rel", 1'b1, 6'b000010);
        step("t2b_idle", 1'b1, 6'b000000);

        // 3: long at E8, repeats at E11/E14/E17, release at E20
        step("t3_E0_press", 1'b0, 6'b100001);
        for (int i = 1; i <= 7; i++) step("t3_hold", 1'b0, 6'b000001);
        step("t3_E8_long", 1'b0, 6'b001001);
        step("t3_E9", 1'b0, 6'b000001);
        step("t3_E10", 1'b0, 6'b000001);
        step("t3_E11_rep", 1'b0, 6'b000101);
        step("t3_E12", 1'b0, 6'b000001);
        step("t3_E13", 1'b0, 6'b000001);
        step("t3_E14_rep", 1'b0, 6'b000101);
        step("t3_E15", 1'b0, 6'b000001);
        step("t3_E16", 1'b0, 6'b000001);
        step("t3_E17_rep", 1'b0, 6'b000101);
        step("t3_E18", 1'b0, 6'b000001);
        step("t3_E19", 1'b0, 6'b000001);
        step("t3_E20_rel", 1'b1, 6'b000010);
        step("t3_idle", 1'b1, 6'b000000);

        // 4: single-cycle press, then immediate re-press
        step("t4_E0_press", 1'b0, 6'b100001);
        step("t4_E1_click", 1'b1, 6'b010010);
        step("t4_E2_repress", 1'b0, 6'b100001);
        step("t4_E3_click", 1'b1, 6'b010010);
        step("t4_idle", 1'b1, 6'b000000);

        // 5: reset released while button held low
        btn_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reset", 6'b000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("t5_wait_low", 1'b0, 6'b000000);
        step("t5_seen_high", 1'b1, 6'b000000);
        step("t5_press", 1'b0, 6'b100001);
        step("t5_click", 1'b1, 6'b010010);

        // 6: asynchronous reset in REPEAT, between repeat pulses
        step("t6_E0_press", 1'b0, 6'b100001);
        for (int i = 1; i <= 7; i++) step("t6_hold", 1'b0, 6'b000001);
        step("t6_E8_long", 1'b0, 6'b001001);
        step("t6_E9", 1'b0, 6'b000001);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 6'b000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step("t6_no_rep", 1'b0, 6'b000000);
        step("t6_no_rel", 1'b1, 6'b000000);
        step("t6_press", 1'b0, 6'b100001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
